// File: rtl/swd_host.sv
// ============================================================================
//  Module   : swd_host
//  Purpose  : SWD initiator. Turns one DP/AP transaction request into a
//             complete SWD packet (request, turnaround, ACK, data, parity and
//             idle clocks), or issues a line reset. Returns the ACK, the read
//             data and a read-parity error flag.
//  Ports    : CLK, RESET (synchronous, active high)
//             req_*  : request handshake and fields (captured at acceptance)
//             rsp_*  : single-cycle completion pulse and held response fields
//             SWDCLK/SWDOUT/SWDOUTEN/SWDIN : SWD line toward the target
//  Options  : `define SWD_WAIT_RETRY_EN to retry a WAIT ACK automatically,
//             up to MAX_RETRY times, before reporting completion.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module swd_host #(
  parameter int CLK_DIV     = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int MAX_RETRY   = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_linereset,
  input  logic        req_apndp,
  input  logic        req_rnw,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_parity_err,
  output logic        SWDCLK,
  output logic        SWDOUT,
  output logic        SWDOUTEN,
  input  logic        SWDIN
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       ACK_OK   = 3'b001;
  localparam logic [2:0]       ACK_WAIT = 3'b010;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_TRN1, S_ACK, S_RDATA, S_RPAR, S_TRN2,
    S_WDATA, S_WPAR, S_IDLE_CLKS, S_LRST, S_DONE
  } state_t;

  state_t             state;
  logic [5:0]         bit_cnt;   // bits left in the current state, minus one
  logic [DIV_W-1:0]   div_cnt;
  logic               phase;     // 0 = SWDCLK low half, 1 = high half
  logic               apndp_q;
  logic               rnw_q;
  logic [1:0]         addr_q;
  logic [31:0]        wdata_q;
  logic               lrst_q;
  logic [31:0]        tx_sr;     // remaining bits of the header / write word
  logic [2:0]         ack_sr;
  logic [31:0]        rdata_sr;
  logic               par_err_q;
`ifdef SWD_WAIT_RETRY_EN
  logic [3:0]         retry_cnt;
`endif

  // Request header, transmitted bit 0 first.
  function automatic logic [7:0] hdr_of(input logic ap, input logic rnw,
                                        input logic [1:0] a);
    return {1'b1, 1'b0, ap ^ rnw ^ a[0] ^ a[1], a[1], a[0], rnw, ap, 1'b1};
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_IDLE;
      bit_cnt        <= '0;
      div_cnt        <= '0;
      phase          <= 1'b0;
      apndp_q        <= 1'b0;
      rnw_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      lrst_q         <= 1'b0;
      tx_sr          <= '0;
      ack_sr         <= '0;
      rdata_sr       <= '0;
      par_err_q      <= 1'b0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_ack        <= '0;
      rsp_rdata      <= '0;
      rsp_parity_err <= 1'b0;
      SWDCLK         <= 1'b0;
      SWDOUT         <= 1'b0;
      SWDOUTEN       <= 1'b0;
`ifdef SWD_WAIT_RETRY_EN
      retry_cnt      <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (req_valid && req_ready) begin
        // Both a packet and a line reset start by driving a 1 (Start bit).
        req_ready <= 1'b0;
        apndp_q   <= req_apndp;
        rnw_q     <= req_rnw;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        lrst_q    <= req_linereset;
        div_cnt   <= '0;
        phase     <= 1'b0;
        SWDCLK    <= 1'b0;
        SWDOUT    <= 1'b1;
        SWDOUTEN  <= 1'b1;
`ifdef SWD_WAIT_RETRY_EN
        retry_cnt <= '0;
`endif
        if (req_linereset) begin
          state   <= S_LRST;
          bit_cnt <= 6'd55;
        end else begin
          state   <= S_REQ;
          bit_cnt <= 6'd7;
          tx_sr   <= {24'd0, hdr_of(req_apndp, req_rnw, req_addr) >> 1};
        end
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end else if (state != S_IDLE) begin
        if (!phase) begin
          if (div_cnt == DIV_LAST) begin
            // Last cycle before the rising edge: sample the target.
            phase   <= 1'b1;
            div_cnt <= '0;
            SWDCLK  <= 1'b1;
            case (state)
              S_ACK:   ack_sr    <= {SWDIN, ack_sr[2:1]};
              S_RDATA: rdata_sr  <= {SWDIN, rdata_sr[31:1]};
              S_RPAR:  par_err_q <= (^rdata_sr) ^ SWDIN;
              default: ;
            endcase
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end else if (div_cnt != DIV_LAST) begin
          div_cnt <= div_cnt + DIV_W'(1);
        end else begin
          // End of bit: the next bit's line values are set here so they
          // appear on the first cycle of its low phase.
          phase   <= 1'b0;
          div_cnt <= '0;
          SWDCLK  <= 1'b0;
          if (bit_cnt != 6'd0) begin
            bit_cnt <= bit_cnt - 6'd1;
            if (state == S_REQ || state == S_WDATA) begin
              SWDOUT <= tx_sr[0];
              tx_sr  <= tx_sr >> 1;
            end
          end else begin
            case (state)
              S_REQ: begin
                state    <= S_TRN1;
                SWDOUT   <= 1'b0;
                SWDOUTEN <= 1'b0;
              end
              S_TRN1: begin
                state   <= S_ACK;
                bit_cnt <= 6'd2;
              end
              S_ACK: begin
                if (ack_sr == ACK_OK && rnw_q) begin
                  state   <= S_RDATA;
                  bit_cnt <= 6'd31;
                end else begin
                  state   <= S_TRN2;
                end
              end
              S_RDATA: state <= S_RPAR;
              S_RPAR:  state <= S_TRN2;
              S_TRN2: begin
                SWDOUTEN <= 1'b1;
                if (ack_sr == ACK_OK && !rnw_q) begin
                  state   <= S_WDATA;
                  bit_cnt <= 6'd31;
                  SWDOUT  <= wdata_q[0];
                  tx_sr   <= wdata_q >> 1;
                end else begin
                  state   <= S_IDLE_CLKS;
                  bit_cnt <= 6'(IDLE_CYCLES - 1);
                  SWDOUT  <= 1'b0;
                end
              end
              S_WDATA: begin
                state  <= S_WPAR;
                SWDOUT <= ^wdata_q;
              end
              S_WPAR, S_LRST: begin
                state   <= S_IDLE_CLKS;
                bit_cnt <= 6'(IDLE_CYCLES - 1);
                SWDOUT  <= 1'b0;
              end
              S_IDLE_CLKS: begin
`ifdef SWD_WAIT_RETRY_EN
                if (!lrst_q && ack_sr == ACK_WAIT && retry_cnt < 4'(MAX_RETRY)) begin
                  // Re-issue the identical packet without reporting.
                  retry_cnt <= retry_cnt + 4'd1;
                  state     <= S_REQ;
                  bit_cnt   <= 6'd7;
                  SWDOUT    <= 1'b1;
                  SWDOUTEN  <= 1'b1;
                  tx_sr     <= {24'd0, hdr_of(apndp_q, rnw_q, addr_q) >> 1};
                end else
`endif
                begin
                  state     <= S_DONE;
                  rsp_valid <= 1'b1;
                  req_ready <= 1'b1;
                  SWDOUT    <= 1'b0;
                  SWDOUTEN  <= 1'b0;
                  rsp_ack   <= lrst_q ? 3'b000 : ack_sr;
                  if (!lrst_q && ack_sr == ACK_OK && rnw_q) begin
                    rsp_rdata      <= rdata_sr;
                    rsp_parity_err <= par_err_q;
                  end else begin
                    rsp_parity_err <= 1'b0;
                  end
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_swd_host.sv
// ============================================================================
//  Module   : tb_swd_host
//  Purpose  : Directed self-checking bench for swd_host with CLK_DIV=1.
//             A bit-level target model drives SWDIN from a per-bit stream and
//             the bench captures SWDOUT/SWDOUTEN for each SWD bit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_swd_host;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_linereset = 1'b0;
  logic        req_apndp = 1'b0;
  logic        req_rnw = 1'b0;
  logic [1:0]  req_addr = 2'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        SWDIN = 1'b0;
  logic        req_ready, rsp_valid, rsp_parity_err;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic        SWDCLK, SWDOUT, SWDOUTEN;

  always #5 CLK = ~CLK;

  swd_host #(.CLK_DIV(1), .IDLE_CYCLES(8), .MAX_RETRY(15)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_linereset(req_linereset), .req_apndp(req_apndp), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata),
    .rsp_parity_err(rsp_parity_err),
    .SWDCLK(SWDCLK), .SWDOUT(SWDOUT), .SWDOUTEN(SWDOUTEN), .SWDIN(SWDIN)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [255:0] tgt, cap_out, cap_oen, exp_out, exp_oen;
  int  nbits;
  bit  got_rsp, clk_bad, busy_ready;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge. Issues one request and runs bit by bit until
  // rsp_valid is seen or the bit budget runs out.
  task automatic run_req(input bit lrst, input bit ap, input bit rnw,
                         input logic [1:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_linereset = lrst; req_apndp = ap; req_rnw = rnw;
    req_addr = a; req_wdata = wd;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    cap_out = '0; cap_oen = '0; nbits = 0; got_rsp = 0; clk_bad = 0;
    busy_ready = req_ready;
    for (int b = 0; b < 256; b++) begin
      if (rsp_valid) begin
        got_rsp = 1;
        break;
      end
      cap_out[b] = SWDOUT;
      cap_oen[b] = SWDOUTEN;
      if (SWDCLK !== 1'b0) clk_bad = 1;
      SWDIN = tgt[b];
      @(posedge CLK); #1;
      if (SWDCLK !== 1'b1) clk_bad = 1;
      @(posedge CLK); #1;
      nbits++;
    end
    SWDIN = 1'b0;
  endtask

  initial begin
    bit saw_rsp;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    // Reset state
    chk("reset_outputs",
        {SWDCLK, SWDOUT, SWDOUTEN, req_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_parity_err},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 1'b0});

    // DP read IDCODE: ACK OK, data 0x2BA01477, correct parity
    tgt = '0; tgt[11:9] = 3'b001; tgt[43:12] = 32'h2BA01477; tgt[44] = ^32'h2BA01477;
    run_req(0, 0, 1, 2'd0, 32'h0);
    exp_out = '0; exp_out[7:0] = 8'hA5;
    exp_oen = '0; exp_oen[7:0] = 8'hFF; exp_oen[53:46] = 8'hFF;
    chk("rd_got_rsp", got_rsp, 1'b1);
    chk("rd_cycles", 2 * nbits, 108);
    chk("rd_swdout", cap_out, exp_out);
    chk("rd_swdouten", cap_oen, exp_oen);
    chk("rd_swdclk_shape", clk_bad, 1'b0);
    chk("rd_ready_busy", busy_ready, 1'b0);
    chk("rd_ready_done", req_ready, 1'b1);
    chk("rd_rsp", {rsp_ack, rsp_rdata, rsp_parity_err}, {3'b001, 32'h2BA01477, 1'b0});
    @(posedge CLK); #1;
    chk("rd_valid_pulse", rsp_valid, 1'b0);

    // DP write SELECT (A=2), data 0x000000F0
    tgt = '0; tgt[11:9] = 3'b001;
    run_req(0, 0, 0, 2'd2, 32'h000000F0);
    exp_out = '0; exp_out[7:0] = 8'hB1; exp_out[44:13] = 32'h000000F0; exp_out[45] = 1'b0;
    exp_oen = '0; exp_oen[7:0] = 8'hFF; exp_oen[45:13] = {33{1'b1}}; exp_oen[53:46] = 8'hFF;
    chk("wr_cycles", 2 * nbits, 108);
    chk("wr_swdout", cap_out, exp_out);
    chk("wr_swdouten", cap_oen, exp_oen);
    chk("wr_rsp", {rsp_ack, rsp_rdata, rsp_parity_err}, {3'b001, 32'h2BA01477, 1'b0});
    @(posedge CLK); #1;

    // AP read A=3 with corrupted parity
    tgt = '0; tgt[11:9] = 3'b001; tgt[43:12] = 32'h12345678; tgt[44] = ~(^32'h12345678);
    run_req(0, 1, 1, 2'd3, 32'h0);
    exp_out = '0; exp_out[7:0] = 8'h9F;
    chk("perr_swdout", cap_out, exp_out);
    chk("perr_rsp", {rsp_ack, rsp_rdata, rsp_parity_err}, {3'b001, 32'h12345678, 1'b1});
    @(posedge CLK); #1;

    // AP write A=1 answered with FAULT: no data phase
    tgt = '0; tgt[11:9] = 3'b100;
    run_req(0, 1, 0, 2'd1, 32'hFFFFFFFF);
    exp_out = '0; exp_out[7:0] = 8'h8B;
    exp_oen = '0; exp_oen[7:0] = 8'hFF; exp_oen[20:13] = 8'hFF;
    chk("fault_cycles", 2 * nbits, 42);
    chk("fault_swdout", cap_out, exp_out);
    chk("fault_swdouten", cap_oen, exp_oen);
    chk("fault_rsp", {rsp_ack, rsp_rdata, rsp_parity_err}, {3'b100, 32'h12345678, 1'b0});
    @(posedge CLK); #1;

    // Line reset
    tgt = '0;
    run_req(1, 0, 0, 2'd0, 32'h0);
    exp_out = '0; exp_out[55:0] = {56{1'b1}};
    exp_oen = '0; exp_oen[63:0] = {64{1'b1}};
    chk("lrst_cycles", 2 * nbits, 128);
    chk("lrst_swdout", cap_out, exp_out);
    chk("lrst_swdouten", cap_oen, exp_oen);
    chk("lrst_rsp", {rsp_ack, rsp_rdata, rsp_parity_err}, {3'b000, 32'h12345678, 1'b0});
    @(posedge CLK); #1;

    // DP read IDCODE: target answers WAIT, WAIT, then OK
    tgt = '0; tgt[11:9] = 3'b010; tgt[32:30] = 3'b010;
    tgt[53:51] = 3'b001; tgt[85:54] = 32'h2BA01477; tgt[86] = ^32'h2BA01477;
    run_req(0, 0, 1, 2'd0, 32'h0);
`ifdef SWD_WAIT_RETRY_EN
    exp_out = '0; exp_out[7:0] = 8'hA5; exp_out[28:21] = 8'hA5; exp_out[49:42] = 8'hA5;
    exp_oen = '0; exp_oen[7:0] = 8'hFF; exp_oen[20:13] = 8'hFF; exp_oen[28:21] = 8'hFF;
    exp_oen[41:34] = 8'hFF; exp_oen[49:42] = 8'hFF; exp_oen[95:88] = 8'hFF;
    chk("wait_cycles", 2 * nbits, 192);
    chk("wait_swdout", cap_out, exp_out);
    chk("wait_swdouten", cap_oen, exp_oen);
    chk("wait_rsp", {rsp_ack, rsp_rdata}, {3'b001, 32'h2BA01477});
`else
    exp_out = '0; exp_out[7:0] = 8'hA5;
    exp_oen = '0; exp_oen[7:0] = 8'hFF; exp_oen[20:13] = 8'hFF;
    chk("wait_cycles", 2 * nbits, 42);
    chk("wait_swdout", cap_out, exp_out);
    chk("wait_swdouten", cap_oen, exp_oen);
    chk("wait_rsp", {rsp_ack, rsp_rdata}, {3'b010, 32'h12345678});
`endif
    @(posedge CLK); #1;
    chk("wait_single_pulse", rsp_valid, 1'b0);

    // Reset in the middle of a line reset
    req_valid = 1'b1; req_linereset = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0; req_linereset = 1'b0;
    repeat (20) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_outputs",
        {SWDCLK, SWDOUT, SWDOUTEN, req_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_parity_err},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 1'b0});
    RESET = 1'b0;
    saw_rsp = 0;
    repeat (150) begin
      @(posedge CLK); #1;
      if (rsp_valid) saw_rsp = 1;
    end
    chk("midrst_no_rsp", saw_rsp, 1'b0);
    chk("midrst_idle_line", {SWDCLK, SWDOUTEN}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/swd_host.md
Name: swd_host

Overview:
- SWD initiator that drives SWDCLK/SWDIO toward an SWD target, such as the CM3 SoC debug port. Used for in-fabric self-test of the debug port and as a bridge from an on-chip controller to external targets.
- Converts one transaction request (DP/AP, read/write, address, write data) into a complete SWD packet: request, turnaround, ACK, data, parity, idle clocks.
- Returns the ACK, read data and a parity-error flag.
- Also issues a line reset on command.

Parameters:
- CLK_DIV, 4, CLK cycles per SWDCLK half-period (minimum 1); one SWD bit lasts 2*CLK_DIV CLK cycles.
- IDLE_CYCLES, 8, idle bits (SWDIO driven 0) clocked after every packet and after line reset.
- MAX_RETRY, 15, maximum automatic retries on a WAIT ACK (used only with SWD_WAIT_RETRY_EN).

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- req_valid  input  1  transaction request valid
- req_ready  output  1  block idle and accepting a request
- req_linereset  input  1  when set with req_valid: perform a line reset instead of a packet
- req_apndp  input  1  0=DP, 1=AP
- req_rnw  input  1  1=read, 0=write
- req_addr  input  2  A[3:2]
- req_wdata  input  32  write data
- rsp_valid  output  1  single-cycle pulse; transaction complete
- rsp_ack  output  3  ACK received, bit0 first on the wire; 3'b000 after a line reset
- rsp_rdata  output  32  read data; valid only for an OK read
- rsp_parity_err  output  1  read-data parity mismatch
- SWDCLK  output  1  SWD clock to target
- SWDOUT  output  1  data driven to target
- SWDOUTEN  output  1  output enable for the top-level tristate
- SWDIN  input  1  data from target (already synchronised)

Behaviour:
- Reset values: SWDCLK=0, SWDOUT=0, SWDOUTEN=0, req_ready=1, rsp_valid=0, rsp_ack=0, rsp_rdata=0, rsp_parity_err=0, FSM=IDLE.
- Reset mid-packet aborts immediately to these values. No completion is reported.
- Bit timing:
  - SWDCLK is low for the first CLK_DIV cycles of each bit and high for the next CLK_DIV cycles.
  - SWDOUT and SWDOUTEN update on the first cycle of the low phase.
  - SWDIN is sampled on the last CLK cycle of the low phase, i.e. just before the rising edge.
  - SWDCLK stays 0 in IDLE.
- Handshake:
  - A request is accepted when req_valid && req_ready; req_ready drops the following cycle.
  - Request fields are captured at acceptance.
  - rsp_valid pulses one cycle after the final idle bit; req_ready returns to 1 in the same cycle.
  - Response fields hold until the next rsp_valid.
- FSM states and transitions:
  - IDLE -> LRST if req_linereset, otherwise -> REQ.
  - REQ: 8 bits, driven. Order: Start=1, APnDP, RnW, A2, A3, Parity (even parity over the 4 header bits), Stop=0, Park=1.
  - TRN1: 1 bit, SWDOUTEN=0.
  - ACK: 3 bits, sampled.
  - ACK=001 (OK) and read -> RDATA: 32 bits sampled LSB first, then RPAR: 1 bit sampled.
    - rsp_parity_err = XOR of the 32 data bits != parity bit.
    - Then TRN2: 1 bit, undriven.
  - ACK=001 (OK) and write -> TRN2: 1 bit, then WDATA: 32 bits driven LSB first, then WPAR: even parity driven.
  - Any other ACK (WAIT, FAULT, or no-response 111/000) -> TRN2 -> IDLE_CLKS. No data phase, rsp_rdata unchanged.
  - IDLE_CLKS: IDLE_CYCLES bits, SWDOUT=0, SWDOUTEN=1.
  - DONE: rsp_valid pulse -> IDLE.
  - LRST: 56 bits with SWDOUT=1, SWDOUTEN=1 -> IDLE_CLKS -> DONE with rsp_ack=000.
- SWDOUTEN is 1 in REQ, WDATA, WPAR, LRST and IDLE_CLKS; 0 in every other state.
- Bit counter: 6 bits, counts down, reloaded on each state entry.
- Divider counter: wraps at CLK_DIV-1; no extra cycles are inserted at state boundaries.
- req_valid while busy is ignored (req_ready=0).

Optional Feature:
- Macro: SWD_WAIT_RETRY_EN.
- Defined:
  - A WAIT ACK (010) leads to TRN2 -> IDLE_CLKS, then re-issues the same packet from REQ without pulsing rsp_valid.
  - This repeats up to MAX_RETRY times. After the final WAIT, the block completes with rsp_ack=010.
  - A 4-bit retry counter clears on each accepted request.
- Undefined: WAIT completes immediately like FAULT; no retry counter is present.

Test Plan:
- DP read, A=0 (IDCODE), CLK_DIV=1; target model ACK=001, data 0x2BA01477, correct parity -> REQ bits (LSB first) = 0xA5; rsp_ack=001, rsp_rdata=0x2BA01477, rsp_parity_err=0; total 8+1+3+33+1+8 = 54 bits = 108 CLK cycles from acceptance to rsp_valid.
- DP write, A=2 (SELECT), wdata 0x000000F0 -> REQ = 0xB1; after TRN2 the driven data is 0x000000F0 LSB first with parity 0; rsp_ack=001.
- Read with a corrupted parity bit from the target -> rsp_parity_err=1, rsp_rdata still holds the sampled word.
- FAULT ACK (100) on a write -> no data phase; SWDOUTEN=0 for exactly 1 bit after ACK, then 8 idle bits; rsp_ack=100.
- Line reset -> 56 bits of SWDOUT=1 with SWDOUTEN=1, then 8 bits of 0; rsp_ack=000. Assert RESET mid-LRST -> all outputs at reset values next cycle and no rsp_valid.
- With SWD_WAIT_RETRY_EN, target returns WAIT twice then OK -> exactly 3 REQ phases, one rsp_valid, rsp_ack=001. Without the macro -> one REQ phase, rsp_ack=010.
